// File: rtl/uart_pkg.sv
// Shared types, defaults and helpers for the UART receive path.
package uart_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_BAUD_RATE  = 115200;
   localparam int unsigned DEF_CLK_FREQ   = 100_000_000;

   typedef enum logic [1:0] {
      STT_IDLE,
      STT_START,
      STT_DATA,
      STT_STOP
   } rx_state_e;

   // Number of system clocks per line bit.
   function automatic int unsigned pulse_width(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_rx_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;

   // Metastability filter: d -> meta_q -> q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         q      <= RESET_VAL;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: oversampling FSM, shift register and 1-entry output buffer.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
   parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_sig,
   output logic [DATA_WIDTH-1:0] data_to_sink,
   output logic                  valid_to_sink,
   input  logic                  ready_from_sink,
   output logic                  frame_err,
   output logic                  overrun_err
);

   localparam int unsigned PULSE_WIDTH      = pulse_width(CLK_FREQ, BAUD_RATE);
   localparam int unsigned HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
   localparam int unsigned CNT_W            = $clog2(PULSE_WIDTH) + 1;
   localparam int unsigned BIT_W            = $clog2(DATA_WIDTH);

   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(PULSE_WIDTH - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_PULSE_WIDTH - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

   logic                  rx_s;
   rx_state_e             state_q, state_d;
   logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  armed_q, armed_d;
   logic                  done_ok, done_bad;
   logic [DATA_WIDTH-1:0] data_d;
   logic                  valid_d, frame_err_d, overrun_err_d;

   uart_rx_sync #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_sig),
      .q   (rx_s)
   );

   // Frame FSM: start-bit qualification, mid-bit data sampling, stop-bit check.
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      armed_d   = armed_q;
      done_ok   = 1'b0;
      done_bad  = 1'b0;
      case (state_q)
         STT_IDLE: begin
            // armed_q means the line has been seen high since the last frame,
            // so a held-low line (break) cannot retrigger.
            if (rx_s) begin
               armed_d = 1'b1;
            end else begin
               armed_d = 1'b0;
               if (armed_q) begin
                  state_d   = STT_START;
                  clk_cnt_d = HALF_LOAD;
               end
            end
         end
         STT_START: begin
            if (clk_cnt_q != '0) begin
               clk_cnt_d = clk_cnt_q - 1'b1;
            end else if (!rx_s) begin
               state_d   = STT_DATA;
               bit_cnt_d = '0;
               clk_cnt_d = FULL_LOAD;
            end else begin
               // Line back high at mid start bit: glitch, drop silently.
               state_d = STT_IDLE;
               armed_d = 1'b1;
            end
         end
         STT_DATA: begin
            if (clk_cnt_q != '0) begin
               clk_cnt_d = clk_cnt_q - 1'b1;
            end else begin
               shift_d[bit_cnt_q] = rx_s;
               clk_cnt_d          = FULL_LOAD;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = STT_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         STT_STOP: begin
            if (clk_cnt_q != '0) begin
               clk_cnt_d = clk_cnt_q - 1'b1;
            end else begin
               state_d  = STT_IDLE;
               armed_d  = rx_s;
               done_ok  = rx_s;
               done_bad = ~rx_s;
            end
         end
         default: state_d = STT_IDLE;
      endcase
   end

   // Output buffer: load on good frame, drop and flag overrun if still occupied.
   always_comb begin
      data_d        = data_to_sink;
      valid_d       = valid_to_sink;
      frame_err_d   = done_bad;
      overrun_err_d = 1'b0;
      if (done_ok) begin
         if (!valid_to_sink || ready_from_sink) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_err_d = 1'b1;
         end
      end else if (valid_to_sink && ready_from_sink) begin
         valid_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= STT_IDLE;
         clk_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         armed_q       <= 1'b0;
         data_to_sink  <= '0;
         valid_to_sink <= 1'b0;
         frame_err     <= 1'b0;
         overrun_err   <= 1'b0;
      end else begin
         state_q       <= state_d;
         clk_cnt_q     <= clk_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         armed_q       <= armed_d;
         data_to_sink  <= data_d;
         valid_to_sink <= valid_d;
         frame_err     <= frame_err_d;
         overrun_err   <= overrun_err_d;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model plus directed literal checks.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 1_000_000;
   localparam int unsigned BAUD     = 100_000;
   localparam int          PW       = 10;
   // Line fall to valid: 2 sync stages, 1 idle detect, half bit, 9 bit times.
   localparam int          LAT      = 2 + 1 + PW / 2 + 9 * PW;

   typedef struct {
      int         at;
      bit         good;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_sig;
   logic       ready_from_sink;
   logic [7:0] data_to_sink;
   logic       valid_to_sink;
   logic       frame_err;
   logic       overrun_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   ev_t        ev_q[$];
   ev_t        ev;
   bit         hit;
   logic       exp_valid, exp_fe, exp_ov;
   logic [7:0] exp_data;

   logic [7:0] rx_q[$];
   int         fe_seen, ov_seen;
   int         c2;

   uart_rx #(
      .DATA_WIDTH (8),
      .BAUD_RATE  (BAUD),
      .CLK_FREQ   (CLK_FREQ)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .rx_sig          (rx_sig),
      .data_to_sink    (data_to_sink),
      .valid_to_sink   (valid_to_sink),
      .ready_from_sink (ready_from_sink),
      .frame_err       (frame_err),
      .overrun_err     (overrun_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Frame-level model: each scheduled frame end either offers a byte or flags an error.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         exp_valid = 1'b0;
         exp_data  = 8'h00;
         exp_fe    = 1'b0;
         exp_ov    = 1'b0;
         ev_q.delete();
      end else begin
         exp_fe = 1'b0;
         exp_ov = 1'b0;
         hit    = 1'b0;
         if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
            ev  = ev_q.pop_front();
            hit = 1'b1;
         end
         if (hit && ev.good) begin
            if (!exp_valid || ready_from_sink) begin
               exp_data  = ev.data;
               exp_valid = 1'b1;
            end else begin
               exp_ov = 1'b1;
            end
         end else begin
            if (hit) exp_fe = 1'b1;
            if (exp_valid && ready_from_sink) exp_valid = 1'b0;
         end
      end
   end

   // Per-cycle compare against the model, plus pulse counting.
   always begin
      @(posedge clk);
      #3;
      check("valid", valid_to_sink, exp_valid);
      check("data", data_to_sink, exp_data);
      check("frame_err", frame_err, exp_fe);
      check("overrun_err", overrun_err, exp_ov);
      if (frame_err === 1'b1) fe_seen++;
      if (overrun_err === 1'b1) ov_seen++;
   end

   // Handshake monitor: a transfer happens on the posedge following this sample.
   always begin
      @(negedge clk);
      #1;
      if (rst === 1'b0 && valid_to_sink === 1'b1 && ready_from_sink === 1'b1)
         rx_q.push_back(data_to_sink);
   end

   task automatic clear_obs();
      rx_q.delete();
      fe_seen = 0;
      ov_seen = 0;
   endtask

   task automatic drive_bit(input logic b);
      rx_sig = b;
      repeat (PW) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx_sig = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Call at a negedge; schedules the model event for this frame.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      ev_t e;
      e.at   = cyc + LAT;
      e.good = stop_bit;
      e.data = d;
      ev_q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop_bit);
   endtask

   initial begin
      ev_t e;
      rst             = 1'b1;
      rx_sig          = 1'b1;
      ready_from_sink = 1'b1;
      fe_seen         = 0;
      ov_seen         = 0;

      // 1: reset and quiet idle
      repeat (3) @(negedge clk);
      check("reset_valid", valid_to_sink, 1'b0);
      check("reset_data", data_to_sink, 8'h00);
      rst = 1'b0;
      clear_obs();
      idle(200);
      check("idle_valid", valid_to_sink, 1'b0);
      check("idle_pulses", fe_seen + ov_seen, 0);

      // 2: back-to-back frames, sink always ready
      clear_obs();
      send_frame(8'hA5, 1'b1);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(20);
      check("b2b_count", rx_q.size(), 3);
      if (rx_q.size() == 3) begin
         check("b2b_byte0", rx_q[0], 8'hA5);
         check("b2b_byte1", rx_q[1], 8'h00);
         check("b2b_byte2", rx_q[2], 8'hFF);
      end
      check("b2b_errs", fe_seen + ov_seen, 0);

      // 3: start-bit glitch is ignored
      clear_obs();
      rx_sig = 1'b0;
      repeat (3) @(negedge clk);
      idle(30);
      check("glitch_count", rx_q.size(), 0);
      check("glitch_fe", fe_seen, 0);
      send_frame(8'h3C, 1'b1);
      idle(20);
      check("after_glitch_count", rx_q.size(), 1);
      if (rx_q.size() == 1) check("after_glitch_byte", rx_q[0], 8'h3C);

      // 4: bad stop bit, then a long break
      clear_obs();
      send_frame(8'h55, 1'b0);
      idle(30);
      check("fe_count", fe_seen, 1);
      check("fe_no_valid", rx_q.size(), 0);
      clear_obs();
      e.at   = cyc + LAT;
      e.good = 1'b0;
      e.data = 8'h00;
      ev_q.push_back(e);
      rx_sig = 1'b0;
      repeat (40 * PW) @(negedge clk);
      idle(30);
      check("break_fe_count", fe_seen, 1);
      check("break_no_valid", rx_q.size(), 0);

      // 5a: overrun with sink stalled
      clear_obs();
      ready_from_sink = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(20);
      check("ovr_data", data_to_sink, 8'h11);
      check("ovr_valid", valid_to_sink, 1'b1);
      check("ovr_count", ov_seen, 1);
      ready_from_sink = 1'b1;
      @(negedge clk);
      ready_from_sink = 1'b0;
      idle(5);
      check("drain_valid", valid_to_sink, 1'b0);

      // 5b: accept exactly in the second completion cycle
      clear_obs();
      send_frame(8'h11, 1'b1);
      c2 = cyc + LAT;
      fork
         send_frame(8'h22, 1'b1);
         begin
            while (cyc < c2 - 1) @(negedge clk);
            ready_from_sink = 1'b1;
            @(negedge clk);
            ready_from_sink = 1'b0;
         end
      join
      idle(20);
      check("swap_data", data_to_sink, 8'h22);
      check("swap_valid", valid_to_sink, 1'b1);
      check("swap_no_ovr", ov_seen, 0);
      ready_from_sink = 1'b1;
      idle(5);

      // 6: reset in the middle of bit 4 of 8'hC3
      clear_obs();
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      rx_sig = 1'b0;
      repeat (4) @(negedge clk);
      rst    = 1'b1;
      rx_sig = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(120);
      check("rst_mid_count", rx_q.size(), 0);
      check("rst_mid_errs", fe_seen + ov_seen, 0);
      check("rst_mid_valid", valid_to_sink, 1'b0);
      send_frame(8'h7E, 1'b1);
      idle(20);
      check("after_rst_count", rx_q.size(), 1);
      if (rx_q.size() == 1) check("after_rst_byte", rx_q[0], 8'h7E);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
